// File: rtl/demux_1_4_2bits_reg_if.sv
// Bus between one producer, the 1-to-4 demux and its four lane consumers.
// The master side is the producer plus the four consumers; the slave side is
// the demux itself.
interface demux_1_4_2bits_reg_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic             auto;
  logic [1:0]       ptr;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic             valid_a;
  logic             valid_b;
  logic             valid_c;
  logic             valid_d;
  logic             ready_a;
  logic             ready_b;
  logic             ready_c;
  logic             ready_d;

  modport master (
    output in_data, in_valid, sel, auto, ready_a, ready_b, ready_c, ready_d,
    input  in_ready, ptr, out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d
  );

  modport slave (
    input  in_data, in_valid, sel, auto, ready_a, ready_b, ready_c, ready_d,
    output in_ready, ptr, out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d
  );
endinterface

// File: rtl/demux_1_4_2bits_reg.sv
// Registered 1-to-4 demultiplexer. One input word per transfer is routed to
// lane A..D (chosen by sel, or by a round-robin pointer when auto=1). Each
// lane is a single-entry holding register with a valid/ready handshake; a
// full lane that is drained in the same cycle still accepts a new word.
module demux_1_4_2bits_reg #(
  parameter int                WIDTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  demux_1_4_2bits_reg_if.slave bus
);

  logic [WIDTH-1:0] lane_data_p1 [4];
  logic [3:0]       lane_vld_p1;
  logic [1:0]       ptr_p1;

  logic [3:0]       lane_rdy;
  logic [1:0]       target;
  logic             in_ready;
  logic             accept;

  assign lane_rdy = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};

  // Target lane selection and acceptance are purely combinational.
  always_comb begin
    target   = bus.auto ? ptr_p1 : bus.sel;
    in_ready = !lane_vld_p1[target] || lane_rdy[target];
    accept   = bus.in_valid && in_ready;
  end

  // ---- stage p1: lane holding registers ----
  // Load the target lane on accept; otherwise a delivered word clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        lane_data_p1[i] <= RESET_VAL;
      end
      lane_vld_p1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (target == 2'(i))) begin
          lane_data_p1[i] <= bus.in_data;
          lane_vld_p1[i]  <= 1'b1;
        end else if (lane_vld_p1[i] && lane_rdy[i]) begin
          lane_vld_p1[i]  <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances only on transfers made in auto mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p1 <= 2'd0;
    end else if (accept && bus.auto) begin
      ptr_p1 <= ptr_p1 + 2'd1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ptr      = ptr_p1;
  assign bus.out_a    = lane_data_p1[0];
  assign bus.out_b    = lane_data_p1[1];
  assign bus.out_c    = lane_data_p1[2];
  assign bus.out_d    = lane_data_p1[3];
  assign bus.valid_a  = lane_vld_p1[0];
  assign bus.valid_b  = lane_vld_p1[1];
  assign bus.valid_c  = lane_vld_p1[2];
  assign bus.valid_d  = lane_vld_p1[3];

endmodule

// File: tb/tb_demux_1_4_2bits_reg.sv
// Testbench for demux_1_4_2bits_reg: directed scenarios plus random traffic,
// all checked cycle by cycle against a lane-occupancy reference model.
module tb_demux_1_4_2bits_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model: per-lane word store, occupancy and pointer as integers.
  int   m_word [4];
  bit   m_full [4];
  int   m_ptr;

  demux_1_4_2bits_reg_if #(.WIDTH(2)) bus ();

  demux_1_4_2bits_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_word[i] = 0;
      m_full[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  // Compare every DUT output against the model for the inputs now applied.
  task automatic compare_all(input string tag);
    logic [1:0] o [4];
    logic       v [4];
    int         t;
    bit         exp_rdy;
    o[0] = bus.out_a;   o[1] = bus.out_b;   o[2] = bus.out_c;   o[3] = bus.out_d;
    v[0] = bus.valid_a; v[1] = bus.valid_b; v[2] = bus.valid_c; v[3] = bus.valid_d;
    t = bus.auto ? m_ptr : int'(bus.sel);
    exp_rdy = !m_full[t] || (t == 0 ? bus.ready_a : t == 1 ? bus.ready_b :
                             t == 2 ? bus.ready_c : bus.ready_d);
    chk($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(exp_rdy));
    chk($sformatf("%s ptr", tag), 32'(bus.ptr), 32'(m_ptr));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s out[%0d]", tag, i), 32'(o[i]), 32'(m_word[i]));
      chk($sformatf("%s valid[%0d]", tag, i), 32'(v[i]), 32'(m_full[i]));
    end
  endtask

  // One clock cycle: apply inputs (called at posedge+1), check at the
  // falling edge, then advance the model at the rising edge.
  task automatic step(input string tag, input bit v, input int d, input int s,
                      input bit a, input bit [3:0] r);
    int t;
    bit acc;
    bus.in_valid = v;
    bus.in_data  = 2'(d);
    bus.sel      = 2'(s);
    bus.auto     = a;
    bus.ready_a  = r[0];
    bus.ready_b  = r[1];
    bus.ready_c  = r[2];
    bus.ready_d  = r[3];
    #4;
    compare_all(tag);
    t   = a ? m_ptr : s;
    acc = v && (!m_full[t] || r[t]);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && r[i]) m_full[i] = 1'b0;
    end
    if (acc) begin
      m_word[t] = d;
      m_full[t] = 1'b1;
      if (a) m_ptr = (m_ptr + 1) % 4;
    end
    #1;
  endtask

  task automatic idle(input string tag, input bit [3:0] r);
    step(tag, 1'b0, 0, 0, 1'b0, r);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.sel = '0; bus.auto = 1'b0;
    bus.ready_a = 1'b0; bus.ready_b = 1'b0; bus.ready_c = 1'b0; bus.ready_d = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all("rst_init");
    rst = 1'b0;

    // Directed routing with all consumers stalled.
    step("route0", 1'b1, 1, 0, 1'b0, 4'b0000);
    step("route1", 1'b1, 2, 1, 1'b0, 4'b0000);
    step("route2", 1'b1, 3, 2, 1'b0, 4'b0000);
    step("route3", 1'b1, 0, 3, 1'b0, 4'b0000);
    idle("route_idle", 4'b0000);
    chk("route out_a", 32'(bus.out_a), 32'd1);
    chk("route out_b", 32'(bus.out_b), 32'd2);
    chk("route out_c", 32'(bus.out_c), 32'd3);
    chk("route out_d", 32'(bus.out_d), 32'd0);
    chk("route valid_d", 32'(bus.valid_d), 32'd1);

    // Backpressure on full lane C, then pass-through accept.
    for (int k = 0; k < 5; k++) begin
      step("bp_stall", 1'b1, 1, 2, 1'b0, 4'b0000);
      chk("bp out_c held", 32'(bus.out_c), 32'd3);
    end
    bus.ready_c = 1'b1;
    #1;
    chk("bp pass in_ready", 32'(bus.in_ready), 32'd1);
    step("bp_pass", 1'b1, 1, 2, 1'b0, 4'b0100);
    chk("bp out_c new", 32'(bus.out_c), 32'd1);
    chk("bp valid_c kept", 32'(bus.valid_c), 32'd1);

    // Drain everything, then round-robin stream with sel toggling.
    idle("drain", 4'b1111);
    for (int k = 0; k < 6; k++) begin
      step("rr", 1'b1, k % 4, $urandom_range(0, 3), 1'b1, 4'b1111);
    end
    chk("rr ptr wrap", 32'(bus.ptr), 32'd2);
    chk("rr out_a", 32'(bus.out_a), 32'd0);
    idle("rr_drain", 4'b1111);

    // Asynchronous reset mid-run while lane B holds a word.
    step("pre_rst", 1'b1, 3, 1, 1'b0, 4'b0000);
    chk("pre_rst valid_b", 32'(bus.valid_b), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    chk("async_rst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Auto hold: pointer frozen while auto=0, resumes afterwards.
    step("ah_auto0", 1'b1, 1, 0, 1'b1, 4'b1111);
    step("ah_auto1", 1'b1, 2, 0, 1'b1, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      step("ah_sel", 1'b1, k, 3, 1'b0, 4'b1000);
    end
    chk("ah ptr held", 32'(bus.ptr), 32'd2);
    chk("ah out_d", 32'(bus.out_d), 32'd2);
    step("ah_resume", 1'b1, 3, 0, 1'b1, 4'b0000);
    chk("ah resume out_c", 32'(bus.out_c), 32'd3);
    chk("ah resume valid_c", 32'(bus.valid_c), 32'd1);
    idle("ah_drain", 4'b1111);

    // Independence: lane A stuck full while B streams one word per cycle.
    step("ind_fill", 1'b1, 2, 0, 1'b0, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step("ind_b", 1'b1, k % 4, 1, 1'b0, 4'b0010);
    end
    chk("ind out_a", 32'(bus.out_a), 32'd2);
    chk("ind valid_a", 32'(bus.valid_a), 32'd1);
    idle("ind_drain", 4'b1111);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_4_2bits_reg.md
Name: demux_1_4_2bits_reg

Overview:
- Registered 1-to-4 demultiplexer for 2-bit data: the distributing counterpart to the 4-1 2-bit selector.
- Accepts one input word per transfer and routes it to lane A, B, C or D, chosen by SEL or by an internal round-robin pointer.
- Each lane has a single-entry holding register with valid/ready handshake.
- Sits between a single 2-bit producer and four independent 2-bit consumers.

Parameters:
- WIDTH, 2, data width of IN and of each OUT_x lane.
- RESET_VAL, 0, reset value loaded into every OUT_x data register.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN  input  WIDTH  input data word.
- IN_VALID  input  1  producer has a word on IN.
- IN_READY  output  1  block can accept the word this cycle (combinational).
- SEL  input  2  target lane when AUTO=0: 00=A, 01=B, 10=C, 11=D.
- AUTO  input  1  1 = target comes from internal pointer PTR; SEL ignored.
- PTR  output  2  current round-robin pointer.
- OUT_A, OUT_B, OUT_C, OUT_D  output  WIDTH  lane data registers.
- VALID_A, VALID_B, VALID_C, VALID_D  output  1  lane register holds an undelivered word.
- READY_A, READY_B, READY_C, READY_D  input  1  consumer takes the lane word this cycle.

Behaviour:
- Reset (asynchronous, RST=1):
  - OUT_A..OUT_D = RESET_VAL.
  - VALID_A..VALID_D = 0.
  - PTR = 0.
  - IN_READY is derived from lane state, so with all lanes empty it reads 1.
  - Any words held at reset assertion are discarded.
  - No transfer occurs while RST=1.
- Target lane: t = AUTO ? PTR : SEL. Selection is combinational, so a change on AUTO or SEL takes effect in the same cycle.
- IN_READY = !VALID_t | READY_t.
  - A full target lane that is being drained this cycle still accepts a new word (pass-through, no bubble).
  - IN_READY depends only on lane t; other lanes being full has no effect.
- Accept = IN_VALID & IN_READY. On an accepted transfer at edge k:
  - OUT_t <= IN and VALID_t <= 1.
  - The word is visible from cycle k+1 (1-cycle latency).
- Pop: for each lane x with VALID_x & READY_x and no accept into x that cycle, VALID_x <= 0.
  - OUT_x keeps its last value; it is not cleared.
- Simultaneous pop and accept on the same lane: VALID_x stays 1 and OUT_x is replaced by IN. No data loss, no duplicate delivery.
- Accept into one lane and pops on other lanes in the same cycle are independent; all occur.
- READY_x while VALID_x=0 is ignored.
- PTR:
  - Increments by 1 modulo 4 (3 -> 0) on each accepted transfer while AUTO=1.
  - Holds when AUTO=0 or when there is no accept.
  - Switching AUTO 1 -> 0 -> 1 resumes from the held PTR value.
- Stalled producer: IN_VALID=1 with IN_READY=0 changes no state. The producer holds IN until accepted.
- Every lane register keeps its word indefinitely until popped. Nothing is dropped or overwritten except under the same-cycle pop-and-accept rule above.

Test Plan:
- Reset and idle: assert RST mid-run with VALID_B=1 -> all VALID_x=0, all OUT_x=0, PTR=0, IN_READY=1 immediately, without a clock edge.
- Directed routing: AUTO=0, all READY_x=0; send IN=01/SEL=00, IN=10/SEL=01, IN=11/SEL=10, IN=00/SEL=11 on consecutive cycles -> OUT_A=01, OUT_B=10, OUT_C=11, OUT_D=00, each VALID rising 1 cycle after its accept.
- Backpressure: lane C full, READY_C=0, SEL=10, IN_VALID=1 -> IN_READY=0 and OUT_C unchanged for 5 cycles. Raise READY_C -> same-cycle accept, VALID_C stays 1, OUT_C takes the new word the next cycle.
- Round-robin: AUTO=1, all READY_x=1; stream 6 words 00,01,10,11,00,01 -> they land in lanes A,B,C,D,A,B. PTR sequence 0,1,2,3,0,1,2 (wrap 3 -> 0). SEL toggling during the stream has no effect.
- AUTO hold: AUTO=1, send 2 words (PTR=2); AUTO=0, send 3 words via SEL=11 -> all go to D, PTR stays 2. AUTO=1 -> next word goes to C.
- Independence: lane A full with READY_A=0 while streaming to B with READY_B=1 -> B sustains 1 word/cycle and lane A holds its word unchanged.
